// File: rtl/alu_result_collector_t_c3x2_27bits_18bits.sv
// Collects ALU sums into carry-extended accumulators (one 27x18 lane or five 9-bit SIMD lanes)
// and presents one packed result per packet over a valid/ready handshake.
module alu_result_collector_t_c3x2_27bits_18bits #(
  parameter  int EXT = 4,
  localparam int W0  = 46 + EXT,
  localparam int LW  = 10 + EXT,
  localparam int DW  = 5 * LW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          USE_SIMD,
  input  logic [44:0]   S,
  input  logic [4:0]    lane_cout,
  input  logic          in_valid,
  input  logic          in_last,
  output logic          in_ready,
  output logic [DW-1:0] out_data,
  output logic          out_mode,
  output logic [7:0]    out_beats,
  output logic [4:0]    out_ovf,
  output logic          out_valid,
  input  logic          out_ready
);

  // state | meaning
  // ACC   | accepting beats of the current packet
  // OUT   | result held until downstream takes it
  typedef enum logic {ACC, OUT} state_t;

  state_t               state_q, state_nxt;
  logic [W0-1:0]        acc0_q, acc0_nxt;
  logic [4:0][LW-1:0]   acc_l_q, acc_l_nxt;
  logic [7:0]           beats_q, beats_nxt;
  logic [4:0]           ovf_q, ovf_nxt;
  logic                 mode_q, mode_nxt;
  logic                 first_q, first_nxt;
  logic [DW-1:0]        out_data_nxt;
  logic                 out_mode_nxt;
  logic [7:0]           out_beats_nxt;
  logic [4:0]           out_ovf_nxt;

  logic                 eff_mode;
  logic [W0:0]          sum0;
  logic [LW:0]          sum_l [5];

  assign in_ready  = (state_q == ACC);
  assign out_valid = (state_q == OUT);

  always_comb begin
    eff_mode      = first_q ? USE_SIMD : mode_q;
    // one extra bit on each sum exposes the wrap out of the accumulator MSB
    sum0          = {1'b0, acc0_q} + {{(EXT + 1){1'b0}}, lane_cout[4], S};
    for (int i = 0; i < 5; i++)
      sum_l[i] = {1'b0, acc_l_q[i]} + {{(EXT + 1){1'b0}}, lane_cout[i], S[9*i +: 9]};

    state_nxt     = state_q;
    acc0_nxt      = acc0_q;
    acc_l_nxt     = acc_l_q;
    beats_nxt     = beats_q;
    ovf_nxt       = ovf_q;
    mode_nxt      = mode_q;
    first_nxt     = first_q;
    out_data_nxt  = out_data;
    out_mode_nxt  = out_mode;
    out_beats_nxt = out_beats;
    out_ovf_nxt   = out_ovf;

    case (state_q)
      ACC: begin
        if (in_valid) begin
          first_nxt = 1'b0;
          mode_nxt  = eff_mode;
          beats_nxt = (beats_q == 8'hFF) ? beats_q : beats_q + 8'd1;
          if (eff_mode) begin
            for (int i = 0; i < 5; i++) begin
              acc_l_nxt[i] = sum_l[i][LW-1:0];
              ovf_nxt[i]   = ovf_q[i] | sum_l[i][LW];
            end
          end else begin
            acc0_nxt   = sum0[W0-1:0];
            ovf_nxt[0] = ovf_q[0] | sum0[W0];
          end
          if (in_last) begin
            state_nxt     = OUT;
            out_data_nxt  = eff_mode ? acc_l_nxt : {{(DW - W0){1'b0}}, acc0_nxt};
            out_beats_nxt = beats_nxt;
            out_ovf_nxt   = ovf_nxt;
            out_mode_nxt  = eff_mode;
          end
        end
      end
      OUT: begin
        if (out_ready) begin
          state_nxt = ACC;
          acc0_nxt  = '0;
          acc_l_nxt = '0;
          beats_nxt = '0;
          ovf_nxt   = '0;
          first_nxt = 1'b1;
        end
      end
      default: state_nxt = ACC;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ACC;
      acc0_q    <= '0;
      acc_l_q   <= '0;
      beats_q   <= '0;
      ovf_q     <= '0;
      mode_q    <= 1'b0;
      first_q   <= 1'b1;
      out_data  <= '0;
      out_mode  <= 1'b0;
      out_beats <= '0;
      out_ovf   <= '0;
    end else begin
      state_q   <= state_nxt;
      acc0_q    <= acc0_nxt;
      acc_l_q   <= acc_l_nxt;
      beats_q   <= beats_nxt;
      ovf_q     <= ovf_nxt;
      mode_q    <= mode_nxt;
      first_q   <= first_nxt;
      out_data  <= out_data_nxt;
      out_mode  <= out_mode_nxt;
      out_beats <= out_beats_nxt;
      out_ovf   <= out_ovf_nxt;
    end
  end

endmodule

// File: tb/tb_alu_result_collector_t_c3x2_27bits_18bits.sv
// Directed and randomized packets checked against an arithmetic model of the collector
// (plain integer sums per lane, wrap detected as total >= 2^width).
module tb_alu_result_collector_t_c3x2_27bits_18bits;

  logic        clk = 1'b0;
  logic        reset;
  logic        USE_SIMD;
  logic [44:0] S;
  logic [4:0]  lane_cout;
  logic        in_valid;
  logic        in_last;
  logic        in_ready;
  logic [69:0] out_data;
  logic        out_mode;
  logic [7:0]  out_beats;
  logic [4:0]  out_ovf;
  logic        out_valid;
  logic        out_ready;

  int n_checks = 0;
  int n_fail   = 0;

  logic [44:0] q_s [$];
  logic [4:0]  q_c [$];
  bit          pkt_mode;
  logic [69:0] exp_data;

  alu_result_collector_t_c3x2_27bits_18bits dut (
    .clk(clk), .reset(reset), .USE_SIMD(USE_SIMD), .S(S), .lane_cout(lane_cout),
    .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready), .out_data(out_data),
    .out_mode(out_mode), .out_beats(out_beats), .out_ovf(out_ovf), .out_valid(out_valid),
    .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [69:0] obs, input logic [69:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  function automatic logic [44:0] rand45();
    logic [63:0] r;
    r = {$urandom, $urandom};
    return r[44:0];
  endfunction

  task automatic start_pkt();
    q_s.delete();
    q_c.delete();
  endtask

  // Drive one beat; its mode is recorded only if it is the first of the packet.
  task automatic beat(input bit simd, input logic [44:0] s, input logic [4:0] c,
                      input bit last, input int idle);
    repeat (idle) @(negedge clk);
    @(negedge clk);
    if (q_s.size() == 0) pkt_mode = simd;
    q_s.push_back(s);
    q_c.push_back(c);
    USE_SIMD = simd; S = s; lane_cout = c; in_valid = 1'b1; in_last = last;
    check("in_ready_acc", {69'd0, in_ready}, 70'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0; in_last = 1'b0; S = 'x; lane_cout = 'x; USE_SIMD = $urandom_range(0, 1);
  endtask

  task automatic check_result(input string tag);
    longint unsigned tot;
    int          lt [5];
    logic [4:0]  eo;
    int          nb;
    exp_data = '0;
    eo       = '0;
    if (!pkt_mode) begin
      tot = 0;
      foreach (q_s[k]) tot += 64'({q_c[k][4], q_s[k]});
      eo[0] = (tot >> 50) != 0;
      exp_data[49:0] = tot[49:0];
    end else begin
      for (int i = 0; i < 5; i++) begin
        lt[i] = 0;
        foreach (q_s[k]) lt[i] += int'({q_c[k][i], q_s[k][9*i +: 9]});
        eo[i] = lt[i] >= 16384;
        exp_data[14*i +: 14] = 14'(lt[i]);
      end
    end
    nb = (q_s.size() > 255) ? 255 : q_s.size();
    @(negedge clk);
    check({tag, "_valid"}, {69'd0, out_valid}, 70'd1);
    check({tag, "_in_ready"}, {69'd0, in_ready}, 70'd0);
    check({tag, "_data"}, out_data, exp_data);
    check({tag, "_ovf"}, {65'd0, out_ovf}, {65'd0, eo});
    check({tag, "_beats"}, {62'd0, out_beats}, 70'(nb));
    check({tag, "_mode"}, {69'd0, out_mode}, {69'd0, pkt_mode});
  endtask

  task automatic drain(input int hold);
    repeat (hold) begin
      @(negedge clk);
      check("hold_valid", {69'd0, out_valid}, 70'd1);
      check("hold_data", out_data, exp_data);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    check("drain_valid", {69'd0, out_valid}, 70'd0);
    check("drain_in_ready", {69'd0, in_ready}, 70'd1);
    check("drain_data_kept", out_data, exp_data);
  endtask

  initial begin
    reset = 1'b1; USE_SIMD = 1'b0; S = '0; lane_cout = '0;
    in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_valid", {69'd0, out_valid}, 70'd0);
    check("rst_in_ready", {69'd0, in_ready}, 70'd1);
    check("rst_data", out_data, 70'd0);
    check("rst_beats", {62'd0, out_beats}, 70'd0);
    check("rst_ovf", {65'd0, out_ovf}, 70'd0);
    check("rst_mode", {69'd0, out_mode}, 70'd0);

    // mode 0, three beats of 45'h1FFF_FFFF_FFFF
    start_pkt();
    for (int i = 0; i < 3; i++) beat(1'b0, 45'h1FFF_FFFF_FFFF, 5'd0, i == 2, 0);
    check_result("m0_3beat");
    check("m0_3beat_const", out_data, 70'h5FFF_FFFF_FFFD);
    drain(0);

    // SIMD two beats: 0x3FF + 0x001 per lane
    start_pkt();
    beat(1'b1, {5{9'h1FF}}, 5'b11111, 1'b0, 0);
    beat(1'b1, {5{9'h001}}, 5'b00000, 1'b1, 0);
    check_result("simd_2beat");
    check("simd_2beat_const", out_data, {5{14'h400}});
    drain(1);

    // 16 beats of max term: no wrap; 17 beats: wrap
    start_pkt();
    for (int i = 0; i < 16; i++) beat(1'b0, {45{1'b1}}, 5'b10000, i == 15, 0);
    check_result("m0_16beat");
    check("m0_16beat_const", out_data, 70'h3_FFFF_FFFF_FFF0);
    drain(0);
    start_pkt();
    for (int i = 0; i < 17; i++) beat(1'b0, {45{1'b1}}, 5'b11111, i == 16, 0);
    check_result("m0_17beat");
    check("m0_17beat_ovf", {65'd0, out_ovf}, 70'd1);
    drain(0);

    // backpressure with a beat waiting upstream; it becomes the next packet
    start_pkt();
    for (int i = 0; i < 2; i++) beat(1'b1, rand45(), 5'($urandom), i == 1, 0);
    check_result("bp_pkt");
    USE_SIMD = 1'b0; S = 45'd7; lane_cout = 5'd0; in_valid = 1'b1; in_last = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check("bp_in_ready", {69'd0, in_ready}, 70'd0);
    end
    drain(0);
    start_pkt();
    pkt_mode = 1'b0;
    q_s.push_back(45'd7);
    q_c.push_back(5'd0);
    @(posedge clk);
    #1 in_valid = 1'b0; in_last = 1'b0;
    check_result("bp_next");
    drain(0);

    // mode change mid-packet is ignored
    start_pkt();
    beat(1'b1, rand45(), 5'($urandom), 1'b0, 0);
    beat(1'b0, rand45(), 5'($urandom), 1'b0, 0);
    beat(1'b0, rand45(), 5'($urandom), 1'b1, 0);
    check_result("mode_chg");
    drain(0);

    // reset mid-packet abandons it
    start_pkt();
    beat(1'b0, rand45(), 5'd0, 1'b0, 0);
    beat(1'b0, rand45(), 5'd0, 1'b0, 0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("rst_mid_valid", {69'd0, out_valid}, 70'd0);
    end
    start_pkt();
    beat(1'b0, 45'd5, 5'd0, 1'b1, 0);
    check_result("post_rst");
    check("post_rst_const", out_data, 70'd5);
    drain(0);

    // reset while holding a result
    start_pkt();
    beat(1'b1, rand45(), 5'($urandom), 1'b1, 0);
    check_result("pre_rst_out");
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_out_valid", {69'd0, out_valid}, 70'd0);
    check("rst_out_data", out_data, 70'd0);
    check("rst_out_in_ready", {69'd0, in_ready}, 70'd1);

    // beat counter saturation
    start_pkt();
    for (int i = 0; i < 260; i++) beat(1'b1, rand45(), 5'($urandom), i == 259, 0);
    check_result("sat");
    drain(0);

    // randomized packets
    for (int p = 0; p < 12; p++) begin
      int n;
      bit m;
      n = $urandom_range(1, 24);
      m = 1'($urandom_range(0, 1));
      start_pkt();
      for (int i = 0; i < n; i++)
        beat((i == 0) ? m : 1'($urandom_range(0, 1)),
             ($urandom_range(0, 3) == 0) ? {45{1'b1}} : rand45(),
             5'($urandom), i == n - 1, $urandom_range(0, 1));
      check_result("rand");
      drain($urandom_range(0, 3));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_result_collector_t_c3x2_27bits_18bits.md
Name: alu_result_collector_T_C3x2_27bits_18bits

Overview:
- Sits at the output end of the 45-bit 27+18 SIMD ALU datapath; consumes per-cycle sums S and their lane carry-outs.
- Accumulates a packet of ALU results into carry-extended accumulators: one wide lane in 27x18 mode, five 9-bit lanes in sum-of-9x9 mode.
- Presents one packed result per packet through a valid/ready output handshake.

Parameters:
- EXT, 4, guard bits added above each lane's carry bit. Sets lane accumulator widths: mode 0 = 46+EXT, SIMD = 10+EXT.

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high reset.
- USE_SIMD  input  1  0 = 27x18 (one 45-bit lane), 1 = sum_9x9 (five 9-bit lanes, S[9i+8:9i]); sampled on the first beat of each packet.
- S  input  45  ALU sum for this beat.
- lane_cout  input  5  mode 0: only bit 4 is used, as the 45-bit carry-out. SIMD: bit i is the carry-out of lane i.
- in_valid  input  1  beat present.
- in_last  input  1  final beat of packet; qualified by in_valid.
- in_ready  output  1  collector accepts a beat this cycle.
- out_data  output  5*(10+EXT)  mode 0: [46+EXT-1:0] is the accumulator and upper bits are 0. SIMD: lane i occupies [(10+EXT)(i+1)-1:(10+EXT)i]. Default width 70.
- out_mode  output  1  mode latched for this packet.
- out_beats  output  8  beats accepted in packet, saturating at 255.
- out_ovf  output  5  sticky per-lane accumulator wrap; mode 0 uses bit 0 only.
- out_valid  output  1  result held.
- out_ready  input  1  downstream accepts result.

Behaviour:
- States: ACC and OUT. Reset sets:
  - state = ACC
  - all accumulators = 0, beat counter = 0, ovf = 0, latched mode = 0, first-beat flag = 1
  - out_valid = 0, out_data = 0, out_beats = 0, out_ovf = 0, out_mode = 0
- in_ready = (state == ACC). It is combinational from state only; no dependence on out_ready (no bypass).
- Beat acceptance: in_valid & in_ready.
  - On the first beat, the mode comes from the current USE_SIMD and is latched. Later beats use the latched mode; USE_SIMD changes mid-packet are ignored.
- Term per lane, zero-extended to the accumulator width:
  - mode 0: {lane_cout[4], S[44:0]}.
  - SIMD lane i: {lane_cout[i], S[9i+8:9i]}.
- Accumulation: acc_i <= acc_i + term_i, modulo 2^width.
  - If the add carries out of the accumulator MSB, set ovf_i (sticky for the packet).
  - No overflow is possible for up to 2^EXT beats (16 by default).
- Beat counter increments per accepted beat and saturates at 255.
- Accepted beat with in_last:
  - Next cycle: state = OUT, out_valid = 1.
  - out_data, out_beats, out_ovf and out_mode are registered with the post-add values, including the last beat. Latency is 1 cycle from the last-beat acceptance.
- OUT state:
  - Outputs are held stable while out_valid & !out_ready.
  - On out_ready, the next cycle has out_valid = 0 and state = ACC. Accumulators, counter, ovf and first-beat flag are cleared; out_data keeps its last value.
- in_valid while in OUT: not accepted, because in_ready = 0. The upstream holds the beat.
- Single-beat packet (first beat with in_last): result = that beat's terms, out_beats = 1.
- Unused lanes in mode 0: lanes 1-4 are forced to 0 in out_data; out_ovf[4:1] = 0.
- Reset asserted mid-packet or in OUT: abandon the packet and return to reset values next cycle; no result is emitted.
- X/Z on S is ignored when in_valid = 0.

Test Plan:
- Mode 0, 3 beats: S=45'h1FFF_FFFF_FFFF, cout=0 each, last on beat 3 → out_valid one cycle after beat 3, out_data=0x5FFF_FFFF_FFFD, out_beats=3, out_ovf=0, out_mode=0.
- SIMD, 2 beats: beat 1 all lanes 9'h1FF with lane_cout=5'b11111, beat 2 all lanes 9'h001 with cout=0 → each 14-bit lane = 0x400, out_mode=1.
- Overflow, mode 0: 17 beats of S=all-ones, cout=1 → accumulator wraps and out_ovf[0]=1; same test with 16 beats → out_ovf=0, out_data = 16*(2^46-1).
- Backpressure: hold out_ready=0 for 5 cycles with in_valid=1 → in_ready stays 0, out_data stable. After out_ready=1, in_ready=1 next cycle and the new packet starts from zero.
- Mode change mid-packet: USE_SIMD=1 on beat 1, then 0 on beats 2-3 → out_mode=1 and lane sums are computed in SIMD form for all beats.
- Reset after 2 beats of a 4-beat packet → no out_valid. The next single-beat packet with S=5, cout=0 (mode 0) gives out_data=5, out_beats=1.
